attn_out_writer: RTL and testbench

Sink for the attention pipeline's output stream. It captures each `(row, group, data)` beat into a 128×128-bit output SRAM at address `{group,row}`. Once all 128 entries are written, it replays the buffer to the testbench or host over a valid/ready stream. It absorbs the SRAM's fixed read latency with a small credit-controlled FIFO. It sits between the attention top's `out_*` stream and the final result memory.

---
 rtl/attn_out_writer_pkg.sv | 20 ++
 rtl/attn_out_writer_if.sv | 36 +++
 rtl/attn_rd_fifo.sv | 55 +++++
 rtl/attn_out_writer.sv | 162 ++++++++++++++++
 tb/tb_attn_out_writer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/attn_out_writer_pkg.sv
// Shared types and constants for the attention output writer: state encoding,
// buffer geometry and the {group,row} address map.
package attn_wr_pkg;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 128;

    typedef enum logic [1:0] {
        StCollect,
        StFull,
        StRead
    } attn_wr_state_e;

    // group*4 + row; 31*4+3 = 127 so the concatenation never wraps.
    function automatic logic [AW-1:0] attn_addr(input logic [4:0] group, input logic [1:0] row);
        return {group, row};
    endfunction

endpackage

// File: rtl/attn_out_writer_if.sv
// Stream, SRAM and status signals of the attention output writer. The writer
// takes the slave view; the producer / SRAM / consumer side takes the master view.
interface attn_out_writer_if;

    logic                          in_valid;
    logic [1:0]                    in_row;
    logic [4:0]                    in_group;
    logic [attn_wr_pkg::DW-1:0]    in_data;

    logic                          mem_web;
    logic [attn_wr_pkg::AW-1:0]    mem_a;
    logic [attn_wr_pkg::DW-1:0]    mem_d;
    logic [attn_wr_pkg::DW-1:0]    mem_q;

    logic                          rd_start;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [attn_wr_pkg::DW-1:0]    rd_data;
    logic [attn_wr_pkg::AW-1:0]    rd_addr;

    logic                          full;
    logic                          busy;
    logic [attn_wr_pkg::AW:0]      wr_count;
    logic                          err;

    modport master (
        output in_valid, in_row, in_group, in_data, mem_q, rd_start, rd_ready,
        input  mem_web, mem_a, mem_d, rd_valid, rd_data, rd_addr, full, busy, wr_count, err
    );

    modport slave (
        input  in_valid, in_row, in_group, in_data, mem_q, rd_start, rd_ready,
        output mem_web, mem_a, mem_d, rd_valid, rd_data, rd_addr, full, busy, wr_count, err
    );

endinterface

// File: rtl/attn_rd_fifo.sv
// Small synchronous FIFO that absorbs SRAM read data during readout.
// Depth need not be a power of two; pointers wrap explicitly.
module attn_rd_fifo #(
    parameter int unsigned Depth = 3,
    parameter int unsigned Width = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [Width-1:0]             i_data,
    input  logic                         i_pop,
    output logic [Width-1:0]             o_data,
    output logic                         o_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count
);

    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CW'(Depth));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= (r_wptr == PW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/attn_out_writer.sv
// Captures attention output beats into a 128-entry SRAM, then replays it in address order
// over a credit-controlled valid/ready stream. ATTN_WR_CHK_EN enables duplicate-write detection.
module attn_out_writer
    import attn_wr_pkg::*;
#(
    parameter int unsigned READ_LAT = 2
) (
    input logic             clk,
    input logic             rst_n,
    attn_out_writer_if.slave bus
);

    localparam int unsigned FifoDepth = READ_LAT + 1;
    localparam int unsigned CW        = $clog2(FifoDepth + 1);
    localparam logic [CW:0] FifoDepthW = (CW + 1)'(FifoDepth);

    attn_wr_state_e r_state;
    attn_wr_state_e w_state_nxt;

    logic                r_mem_web;
    logic [AW-1:0]       r_mem_a;
    logic [DW-1:0]       r_mem_d;
    logic [AW:0]         r_wr_count;
    logic [AW:0]         r_iss_cnt;
    logic [AW:0]         r_pop_cnt;
    logic [READ_LAT-1:0] r_pipe;
    logic                r_err;

    logic [AW-1:0]       w_wr_addr;
    logic                w_beat;
    logic                w_dup;
    logic                w_count_inc;
    logic                w_drop;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_last_pop;
    logic                w_rd_valid;
    logic                w_fifo_empty;
    logic [CW-1:0]       w_fifo_count;
    logic [CW-1:0]       w_inflight;
    logic [CW:0]         w_credit;
    logic [DW-1:0]       w_fifo_data;

    assign w_wr_addr   = attn_addr(bus.in_group, bus.in_row);
    assign w_beat      = bus.in_valid && (r_state == StCollect);
    assign w_drop      = bus.in_valid && (r_state != StCollect);
    assign w_count_inc = w_beat && !w_dup;

`ifdef ATTN_WR_CHK_EN
    logic [DEPTH-1:0] r_written;

    assign w_dup = r_written[w_wr_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_written <= '0;
        end else if (w_last_pop) begin
            r_written <= '0;
        end else if (w_beat) begin
            r_written[w_wr_addr] <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // Reads still travelling through the SRAM pipe, including the one whose data is on mem_q now.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    assign w_credit   = {1'b0, w_inflight} + {1'b0, w_fifo_count};
    assign w_rd_valid = !w_fifo_empty;
    assign w_pop      = w_rd_valid && bus.rd_ready;
    assign w_push     = r_pipe[READ_LAT-1];
    assign w_last_pop = w_pop && (r_state == StRead) && (r_pop_cnt == (AW + 1)'(DEPTH - 1));

    // A slot freed by this cycle's pop may be reused by this cycle's issue.
    assign w_issue = (r_state == StRead) && !r_iss_cnt[AW]
                     && ((w_credit - {{CW{1'b0}}, w_pop}) < FifoDepthW);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StCollect: begin
                if (w_count_inc && (r_wr_count == (AW + 1)'(DEPTH - 1))) w_state_nxt = StFull;
            end
            StFull: begin
                if (bus.rd_start) w_state_nxt = StRead;
            end
            StRead: begin
                if (w_last_pop) w_state_nxt = StCollect;
            end
            default: w_state_nxt = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StCollect;
            r_mem_web  <= 1'b1;
            r_mem_a    <= '0;
            r_mem_d    <= '0;
            r_wr_count <= '0;
            r_iss_cnt  <= '0;
            r_pop_cnt  <= '0;
            r_pipe     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_web <= !w_beat;
            if (w_beat) begin
                r_mem_a <= w_wr_addr;
                r_mem_d <= bus.in_data;
            end
            if (w_drop || (w_beat && w_dup)) r_err <= 1'b1;
            if (w_last_pop) begin
                r_wr_count <= '0;
                r_iss_cnt  <= '0;
                r_pop_cnt  <= '0;
            end else begin
                if (w_count_inc) r_wr_count <= r_wr_count + 1'b1;
                if (w_issue)     r_iss_cnt  <= r_iss_cnt + 1'b1;
                if (w_pop)       r_pop_cnt  <= r_pop_cnt + 1'b1;
            end
            r_pipe[0] <= w_issue;
            for (int i = 1; i < READ_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    attn_rd_fifo #(
        .Depth (FifoDepth),
        .Width (DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (bus.mem_q),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // During readout the issue pointer drives the SRAM address directly so a read lands the
    // same cycle it is granted; otherwise the registered write address is presented.
    assign bus.mem_a    = (r_state == StRead) ? r_iss_cnt[AW-1:0] : r_mem_a;
    assign bus.mem_web  = r_mem_web;
    assign bus.mem_d    = r_mem_d;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_data  = w_fifo_data;
    assign bus.rd_addr  = r_pop_cnt[AW-1:0];
    assign bus.full     = (r_state == StFull);
    assign bus.busy     = (r_state == StRead);
    assign bus.wr_count = r_wr_count;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_attn_out_writer.sv
// Directed + randomized bench for attn_out_writer with an SRAM model and a
// last-write-wins reference of the buffer contents.
module tb_attn_out_writer;
    import attn_wr_pkg::*;

    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    attn_out_writer_if bus ();

    attn_out_writer #(
        .READ_LAT (RL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SRAM: write on mem_web=0, read data valid RL cycles after mem_a.
    logic [DW-1:0] sram [DEPTH];
    logic [AW-1:0] a_d1;
    always @(posedge clk) begin
        if (bus.mem_web === 1'b0) sram[bus.mem_a] <= bus.mem_d;
        a_d1       <= bus.mem_a;
        bus.mem_q  <= sram[a_d1];
    end

    // Reference model
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_bitmap [DEPTH];
    int            m_count;
    bit            m_full;
    bit            m_err;

    int n_checks = 0;
    int n_errs   = 0;
    int order [DEPTH+1];
    int n_beats;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_full  = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_bitmap[i] = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_web"},   bus.mem_web, 1'b1);
        chk({tag, "_a"},     bus.mem_a, 0);
        chk({tag, "_d"},     bus.mem_d, 0);
        chk({tag, "_valid"}, bus.rd_valid, 1'b0);
        chk({tag, "_rdata"}, bus.rd_data, 0);
        chk({tag, "_raddr"}, bus.rd_addr, 0);
        chk({tag, "_full"},  bus.full, 1'b0);
        chk({tag, "_busy"},  bus.busy, 1'b0);
        chk({tag, "_cnt"},   bus.wr_count, 0);
        chk({tag, "_err"},   bus.err, 1'b0);
    endtask

    task automatic beat(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit acc;
        bit dup;
        acc = !m_full;
        bus.in_valid = 1'b1;
        bus.in_group = addr[6:2];
        bus.in_row   = addr[1:0];
        bus.in_data  = data;
        if (acc) begin
            dup = m_bitmap[addr];
            ref_mem[addr]  = data;
            m_bitmap[addr] = 1'b1;
`ifdef ATTN_WR_CHK_EN
            if (dup) m_err = 1'b1;
            else     m_count++;
`else
            m_count++;
`endif
            if (m_count == DEPTH) m_full = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("wr_web", bus.mem_web, acc ? 1'b0 : 1'b1);
        if (acc) begin
            chk("wr_addr", bus.mem_a, addr);
            chk("wr_data", bus.mem_d, data);
        end
        chk("wr_full",  bus.full, m_full);
        chk("wr_count", bus.wr_count, m_count);
        chk("wr_err",   bus.err, m_err);
    endtask

    task automatic shuffle(input int lo, input int hi);
        for (int i = hi; i > lo; i--) begin
            int j;
            int t;
            j = lo + $urandom_range(0, i - lo);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
    endtask

    // mode 0: ready held high, 1: alternating, 2: random
    task automatic readout(input int mode, input int stop_after);
        int            pops;
        int            cyc;
        int            first;
        bit            ready;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        pops = 0;
        cyc = 0;
        first = -1;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_addr = '0;
        bus.rd_ready = 1'b0;
        bus.rd_start = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        cyc = 1;
        chk("busy_start", bus.busy, 1'b1);
        chk("full_in_read", bus.full, 1'b0);
        while (pops < stop_after && cyc < 3000) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = cyc[0];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            bus.rd_ready = ready;
            if (bus.rd_valid === 1'b1 && first < 0) begin
                first = cyc;
                if (mode == 0) chk("first_latency", first, RL + 2);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.rd_valid, 1'b1);
                chk("stall_data", bus.rd_data, prev_data);
                chk("stall_addr", bus.rd_addr, prev_addr);
            end
            if (mode == 0 && first >= 0) chk("no_gap", bus.rd_valid, 1'b1);
            chk("credit_limit", 1'(dut.w_credit <= 3), 1'b1);
            if (bus.rd_valid === 1'b1) begin
                chk("rd_addr", bus.rd_addr, pops);
                chk("rd_data", bus.rd_data, ref_mem[pops]);
                if (ready) pops++;
            end
            prev_stall = (bus.rd_valid === 1'b1) && !ready;
            prev_data  = bus.rd_data;
            prev_addr  = bus.rd_addr;
            @(negedge clk);
            cyc++;
        end
        bus.rd_ready = 1'b0;
        if (cyc >= 3000) chk("rd_timeout", pops, stop_after);
        if (stop_after == DEPTH) begin
            model_clear();
            chk("end_busy",  bus.busy, 1'b0);
            chk("end_full",  bus.full, 1'b0);
            chk("end_count", bus.wr_count, 0);
            chk("end_valid", bus.rd_valid, 1'b0);
            chk("end_err",   bus.err, m_err);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        m_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        bus.in_group = '0;
        bus.in_data  = '0;
        bus.rd_start = 1'b0;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        model_clear();
        m_err = 1'b0;

        // Reset state
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // In-order fill, data = addr, full-rate readout
        for (int i = 0; i < DEPTH; i++) beat(AW'(i), DW'(i));
        chk("fill_full", bus.full, 1'b1);
        readout(0, DEPTH);

        // Shuffled fill with marker at (group 31, row 3), then overflow beat in FULL
        for (int i = 0; i < DEPTH; i++) order[i] = i;
        shuffle(0, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            d = (order[i] == 127) ? DW'(16'hDEAD) : {$urandom, $urandom, $urandom, $urandom};
            beat(AW'(order[i]), d);
        end
        beat(AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom, $urandom, $urandom});
        chk("overflow_err", bus.err, 1'b1);
        chk("marker_ref", ref_mem[127], DW'(16'hDEAD));
        readout(1, DEPTH);

        // Random backpressure, reset after 40 pops
        do_reset();
        for (int i = 0; i < DEPTH; i++) order[i] = i;
        shuffle(0, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) beat(AW'(order[i]), {$urandom, $urandom, $urandom, $urandom});
        readout(2, 40);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_clear();
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) beat(AW'(i), {$urandom, $urandom, $urandom, $urandom});
        readout(0, DEPTH);

        // Address 5 written twice, then the other 127 addresses
        do_reset();
        order[0] = 5;
        order[1] = 5;
        n_beats = 2;
        for (int a = 0; a < DEPTH; a++) begin
            if (a != 5) begin
                order[n_beats] = a;
                n_beats++;
            end
        end
        shuffle(2, n_beats - 1);
        for (int i = 0; i < n_beats; i++) begin
            beat(AW'(order[i]), {$urandom, $urandom, $urandom, $urandom});
            if (i == 1) begin
`ifdef ATTN_WR_CHK_EN
                chk("dup_err", bus.err, 1'b1);
                chk("dup_count", bus.wr_count, 1);
`else
                chk("dup_err", bus.err, 1'b0);
                chk("dup_count", bus.wr_count, 2);
`endif
            end
        end
        chk("dup_full", bus.full, 1'b1);
        readout(2, DEPTH);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
